// File: rtl/hashcheck_pkg.sv
// Shared constants and the state encoding for the hashchecker request-side initiator.
package hashcheck_pkg;

   localparam int HASH_W         = 128;
   localparam int DEF_MAX_HASHES = 128;
   localparam int CNT_W          = 8;
   localparam int HIT_W          = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LREQ   = 3'd1,
      LWAIT  = 3'd2,
      CREQ   = 3'd3,
      CWAIT  = 3'd4,
      REPORT = 3'd5,
      DRAIN  = 3'd6,
      ERROR  = 3'd7
   } state_e;

endpackage

// File: rtl/hashcheck_initiator_if.sv
// Bundles the loader, candidate, checker and result signals of the initiator.
// The master modport is the initiator itself; slave is its environment.
interface hashcheck_initiator_if #(
   parameter int TAG_W = 32
);
   import hashcheck_pkg::*;

   logic                load_valid;
   logic [HASH_W-1:0]   load_hash;
   logic                load_ready;
   logic                cand_valid;
   logic [HASH_W-1:0]   cand_hash;
   logic [TAG_W-1:0]    cand_tag;
   logic                cand_ready;
   logic                chk_newrdy;
   logic                chk_checkrdy;
   logic [HASH_W-1:0]   chk_hash;
   logic                chk_resultrdy;
   logic                chk_matchfound;
   logic                res_valid;
   logic                res_match;
   logic [TAG_W-1:0]    res_tag;
   logic [CNT_W-1:0]    loaded_count;
   logic [HIT_W-1:0]    hit_count;
   logic                err;
   logic                busy;

   modport master (
      input  load_valid, load_hash, cand_valid, cand_hash, cand_tag,
      input  chk_resultrdy, chk_matchfound,
      output load_ready, cand_ready, chk_newrdy, chk_checkrdy, chk_hash,
      output res_valid, res_match, res_tag, loaded_count, hit_count, err, busy
   );

   modport slave (
      output load_valid, load_hash, cand_valid, cand_hash, cand_tag,
      output chk_resultrdy, chk_matchfound,
      input  load_ready, cand_ready, chk_newrdy, chk_checkrdy, chk_hash,
      input  res_valid, res_match, res_tag, loaded_count, hit_count, err, busy
   );

endinterface

// File: rtl/hashcheck_wait_timer.sv
// Clear/enable cycle counter that flags expiry once it reaches TIMEOUT and then holds there.
module hashcheck_wait_timer #(
   parameter int TIMEOUT = 31
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int             W     = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]   LIMIT = W'(TIMEOUT);

   logic [W-1:0] r_count;

   // Wait-cycle counter; clear wins over count, saturates at LIMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= {W{1'b0}};
      end else if (i_clr) begin
         r_count <= {W{1'b0}};
      end else if (i_en && (r_count != LIMIT)) begin
         r_count <= r_count + W'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/hashcheck_initiator.sv
// Request-side initiator for the hashchecker: loads targets, queries candidates,
// reports one tagged result per candidate and traps checker stalls in ERROR.
module hashcheck_initiator
   import hashcheck_pkg::*;
#(
   parameter int MAX_HASHES = DEF_MAX_HASHES,
   parameter int TAG_W      = 32,
   parameter int TIMEOUT    = 31
) (
   input  logic                   clk,
   input  logic                   rst,
   hashcheck_initiator_if.master  bus
);

   localparam logic [CNT_W-1:0] MAX_LIMIT = CNT_W'(MAX_HASHES);

   state_e              r_state;
   state_e              w_next_state;
   logic [HASH_W-1:0]   r_chk_hash;
   logic                r_res_valid;
   logic                r_res_match;
   logic [TAG_W-1:0]    r_res_tag;
   logic [CNT_W-1:0]    r_loaded_count;
   logic [HIT_W-1:0]    r_hit_count;
   logic                r_zero_loaded;

   logic w_load_ready;
   logic w_cand_ready;
   logic w_load_acc;
   logic w_cand_acc;
   logic w_mask;
   logic w_expired;
   logic w_timer_en;
   logic w_state_change;

   assign w_load_ready = !rst && (r_state == IDLE) && (r_loaded_count < MAX_LIMIT);
   assign w_cand_ready = !rst && (r_state == IDLE) && !bus.load_valid;
   assign w_load_acc   = bus.load_valid && w_load_ready;
   assign w_cand_acc   = bus.cand_valid && w_cand_ready;

   // Empty checker slots read back as 0, so a zero candidate only counts if 0 was really loaded.
   assign w_mask = (r_chk_hash == {HASH_W{1'b0}}) && !r_zero_loaded && (r_loaded_count < MAX_LIMIT);

   assign w_timer_en     = (r_state == LWAIT) || (r_state == CWAIT) || (r_state == DRAIN);
   assign w_state_change = (w_next_state != r_state);

   hashcheck_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_state_change),
      .i_en      (w_timer_en),
      .o_expired (w_expired)
   );

   // Next-state decode; an acknowledge always wins over a same-cycle timeout.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_load_acc) begin
               w_next_state = LREQ;
            end else if (w_cand_acc && (r_loaded_count != {CNT_W{1'b0}})) begin
               w_next_state = CREQ;
            end else begin
               w_next_state = IDLE;
            end
         end
         LREQ:   w_next_state = LWAIT;
         LWAIT: begin
            if (bus.chk_resultrdy) begin
               w_next_state = DRAIN;
            end else if (w_expired) begin
               w_next_state = ERROR;
            end else begin
               w_next_state = LWAIT;
            end
         end
         CREQ:   w_next_state = CWAIT;
         CWAIT: begin
            if (bus.chk_resultrdy) begin
               w_next_state = REPORT;
            end else if (w_expired) begin
               w_next_state = ERROR;
            end else begin
               w_next_state = CWAIT;
            end
         end
         REPORT: w_next_state = DRAIN;
         DRAIN: begin
            if (!bus.chk_resultrdy) begin
               w_next_state = IDLE;
            end else if (w_expired) begin
               w_next_state = ERROR;
            end else begin
               w_next_state = DRAIN;
            end
         end
         ERROR:  w_next_state = ERROR;
         default: w_next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Checker hash, result pulse and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_chk_hash     <= {HASH_W{1'b0}};
         r_res_valid    <= 1'b0;
         r_res_match    <= 1'b0;
         r_res_tag      <= {TAG_W{1'b0}};
         r_loaded_count <= {CNT_W{1'b0}};
         r_hit_count    <= {HIT_W{1'b0}};
         r_zero_loaded  <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         if (w_load_acc) begin
            r_chk_hash <= bus.load_hash;
            if (bus.load_hash == {HASH_W{1'b0}}) begin
               r_zero_loaded <= 1'b1;
            end
         end else if (w_cand_acc) begin
            r_res_tag <= bus.cand_tag;
            if (r_loaded_count == {CNT_W{1'b0}}) begin
               r_res_valid <= 1'b1;
               r_res_match <= 1'b0;
            end else begin
               r_chk_hash <= bus.cand_hash;
            end
         end
         if ((r_state == LWAIT) && bus.chk_resultrdy) begin
            r_loaded_count <= r_loaded_count + CNT_W'(1);
         end
         // Result is registered on entry to REPORT so the pulse lines up with that state.
         if ((r_state == CWAIT) && bus.chk_resultrdy) begin
            r_res_valid <= 1'b1;
            r_res_match <= bus.chk_matchfound && !w_mask;
         end
         if ((r_state == REPORT) && r_res_match && (r_hit_count != {HIT_W{1'b1}})) begin
            r_hit_count <= r_hit_count + HIT_W'(1);
         end
      end
   end

   assign bus.load_ready   = w_load_ready;
   assign bus.cand_ready   = w_cand_ready;
   assign bus.chk_newrdy   = (r_state == LREQ);
   assign bus.chk_checkrdy = (r_state == CREQ);
   assign bus.chk_hash     = r_chk_hash;
   assign bus.res_valid    = r_res_valid;
   assign bus.res_match    = r_res_match;
   assign bus.res_tag      = r_res_tag;
   assign bus.loaded_count = r_loaded_count;
   assign bus.hit_count    = r_hit_count;
   assign bus.err          = (r_state == ERROR);
   assign bus.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_hashcheck_initiator.sv
// Directed bench for hashcheck_initiator with a behavioural hashchecker responder.
module tb_hashcheck_initiator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   bit   model_dead = 1'b0;

   always #5 clk = ~clk;

   hashcheck_initiator_if #(.TAG_W(32)) bus ();

   hashcheck_initiator #(
      .MAX_HASHES (128),
      .TAG_W      (32),
      .TIMEOUT    (31)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Hashchecker responder: resultrdy 4 cycles after a strobe, 1 cycle for loads, 2 for checks.
   int            mc = 0;
   int            rr_start = -10;
   int            rr_end = -10;
   logic          m_match = 1'b0;
   logic [127:0]  tgt_q[$];

   always @(negedge clk) begin
      mc++;
      if (rst) begin
         tgt_q.delete();
         rr_start = -10;
         rr_end = -10;
         bus.chk_resultrdy = 1'b0;
         bus.chk_matchfound = 1'b0;
      end else begin
         bus.chk_resultrdy = (mc >= rr_start) && (mc <= rr_end);
         bus.chk_matchfound = bus.chk_resultrdy ? m_match : 1'b0;
         if (bus.chk_newrdy) begin
            tgt_q.push_back(bus.chk_hash);
            rr_start = mc + 4;
            rr_end = mc + 4;
         end
         if (bus.chk_checkrdy && !model_dead) begin
            m_match = 1'b0;
            foreach (tgt_q[i]) if (tgt_q[i] == bus.chk_hash) m_match = 1'b1;
            if ((bus.chk_hash == 128'h0) && (tgt_q.size() < 128)) m_match = 1'b1;
            rr_start = mc + 4;
            rr_end = mc + 5;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [127:0] h);
      int n;
      bus.load_valid = 1'b1;
      bus.load_hash = h;
      #1;
      n = 0;
      while (!bus.load_ready && n < 50) begin tick(); n++; end
      tick();
      bus.load_valid = 1'b0;
      n = 0;
      while (!bus.load_ready && n < 50 && bus.loaded_count != 8'd128) begin tick(); n++; end
      checks++;
      if (n >= 50) begin errors++; $display("FAIL load_timeout got=%0d want<50", n); end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.load_ready, bus.cand_ready, bus.chk_newrdy, bus.chk_checkrdy, bus.res_valid,
           bus.res_match, bus.err, bus.busy} !== 8'b0) begin
         errors++; $display("FAIL reset_flags got=%b want=00000000", {bus.load_ready, bus.cand_ready,
            bus.chk_newrdy, bus.chk_checkrdy, bus.res_valid, bus.res_match, bus.err, bus.busy});
      end
      checks++;
      if (bus.chk_hash !== 128'h0 || bus.res_tag !== 32'h0) begin
         errors++; $display("FAIL reset_data got=%h/%h want=0", bus.chk_hash, bus.res_tag);
      end
      checks++;
      if (bus.loaded_count !== 8'd0 || bus.hit_count !== 16'd0) begin
         errors++; $display("FAIL reset_counts got=%0d/%0d want=0/0", bus.loaded_count, bus.hit_count);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.load_ready !== 1'b1 || bus.cand_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset_ready got=%b%b want=11", bus.load_ready, bus.cand_ready);
      end
   endtask

   task automatic test_no_targets;
      int nchk = 0, nres = 0, rcyc = -1;
      logic gm = 1'bx;
      logic [31:0] gt = 32'hx;
      bus.cand_valid = 1'b1;
      bus.cand_hash = 128'h1234;
      bus.cand_tag = 32'd9;
      #1;
      checks++;
      if (bus.cand_ready !== 1'b1) begin errors++; $display("FAIL notgt_ready got=%b want=1", bus.cand_ready); end
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) bus.cand_valid = 1'b0;
         if (bus.chk_checkrdy) nchk++;
         if (bus.res_valid) begin nres++; rcyc = c; gm = bus.res_match; gt = bus.res_tag; end
      end
      checks++;
      if (nchk !== 0) begin errors++; $display("FAIL notgt_checkrdy got=%0d want=0", nchk); end
      checks++;
      if (nres !== 1 || rcyc !== 1) begin errors++; $display("FAIL notgt_res got=%0d@%0d want=1@1", nres, rcyc); end
      checks++;
      if (gm !== 1'b0 || gt !== 32'd9) begin errors++; $display("FAIL notgt_result got=%b/%0d want=0/9", gm, gt); end
   endtask

   task automatic test_load;
      logic [127:0] hs [2];
      hs[0] = {32{4'h1}};
      hs[1] = {32{4'h2}};
      for (int k = 0; k < 2; k++) begin
         int nnew = 0, ncyc = -1, badh = 0;
         bus.load_valid = 1'b1;
         bus.load_hash = hs[k];
         #1;
         checks++;
         if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_c0 got=%b want=1", bus.load_ready); end
         for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin bus.load_valid = 1'b0; bus.load_hash = {128{1'b1}}; end
            if (bus.chk_newrdy) begin nnew++; ncyc = c; end
            if (c <= 6 && bus.chk_hash !== hs[k]) badh++;
            if (c == 5) begin
               checks++;
               if (bus.loaded_count !== 8'(k)) begin errors++; $display("FAIL count_c5 got=%0d want=%0d", bus.loaded_count, k); end
            end
            if (c == 6) begin
               checks++;
               if (bus.loaded_count !== 8'(k + 1) || bus.load_ready !== 1'b0) begin
                  errors++; $display("FAIL count_c6 got=%0d/%b want=%0d/0", bus.loaded_count, bus.load_ready, k + 1);
               end
            end
            if (c == 7) begin
               checks++;
               if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_c7 got=%b want=1", bus.load_ready); end
            end
         end
         checks++;
         if (nnew !== 1 || ncyc !== 1) begin errors++; $display("FAIL newrdy got=%0d@%0d want=1@1", nnew, ncyc); end
         checks++;
         if (badh !== 0) begin errors++; $display("FAIL chk_hash_stable got=%0d want=0", badh); end
      end
   endtask

   task automatic run_candidate(input logic [127:0] h, input logic [31:0] tag,
                                input logic exp_match, input logic [15:0] exp_hits);
      int nchk = 0, ccyc = -1, nres = 0, rcyc = -1;
      logic gm = 1'bx;
      logic [31:0] gt = 32'hx;
      bus.cand_valid = 1'b1;
      bus.cand_hash = h;
      bus.cand_tag = tag;
      #1;
      checks++;
      if (bus.cand_ready !== 1'b1) begin errors++; $display("FAIL cand_ready_c0 tag=%0d got=%b want=1", tag, bus.cand_ready); end
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin bus.cand_valid = 1'b0; bus.cand_hash = {128{1'b1}}; end
         if (bus.chk_checkrdy) begin nchk++; ccyc = c; end
         if (bus.res_valid) begin nres++; rcyc = c; gm = bus.res_match; gt = bus.res_tag; end
         if (c == 7) begin
            checks++;
            if (bus.cand_ready !== 1'b0) begin errors++; $display("FAIL cand_ready_c7 tag=%0d got=%b want=0", tag, bus.cand_ready); end
         end
      end
      checks++;
      if (bus.cand_ready !== 1'b1) begin errors++; $display("FAIL cand_ready_c8 tag=%0d got=%b want=1", tag, bus.cand_ready); end
      checks++;
      if (nchk !== 1 || ccyc !== 1) begin errors++; $display("FAIL checkrdy tag=%0d got=%0d@%0d want=1@1", tag, nchk, ccyc); end
      checks++;
      if (nres !== 1 || rcyc !== 6) begin errors++; $display("FAIL res_valid tag=%0d got=%0d@%0d want=1@6", tag, nres, rcyc); end
      checks++;
      if (gm !== exp_match || gt !== tag) begin
         errors++; $display("FAIL res tag=%0d got=%b/%0d want=%b/%0d", tag, gm, gt, exp_match, tag);
      end
      checks++;
      if (bus.hit_count !== exp_hits) begin errors++; $display("FAIL hit_count tag=%0d got=%0d want=%0d", tag, bus.hit_count, exp_hits); end
   endtask

   task automatic test_candidates;
      run_candidate({32{4'h2}}, 32'd5, 1'b1, 16'd1);
      run_candidate({32{4'h3}}, 32'd6, 1'b0, 16'd1);
   endtask

   task automatic test_zero_mask;
      run_candidate(128'h0, 32'd7, 1'b0, 16'd1);
      do_load(128'h0);
      run_candidate(128'h0, 32'd8, 1'b1, 16'd2);
   endtask

   task automatic test_full;
      int nbad = 0;
      for (int i = 0; i < 125; i++) do_load({96'h0, 32'(i + 256)});
      checks++;
      if (bus.loaded_count !== 8'd128 || bus.load_ready !== 1'b0) begin
         errors++; $display("FAIL full_count got=%0d/%b want=128/0", bus.loaded_count, bus.load_ready);
      end
      bus.load_valid = 1'b1;
      bus.load_hash = {32{4'hA}};
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.load_ready || bus.chk_newrdy || bus.busy) nbad++;
      end
      checks++;
      if (nbad !== 0) begin errors++; $display("FAIL full_holdoff got=%0d want=0", nbad); end
      bus.load_valid = 1'b0;
      run_candidate({32{4'h2}}, 32'd10, 1'b1, 16'd3);
   endtask

   task automatic test_timeout;
      int nchk = 0, nres = 0;
      model_dead = 1'b1;
      bus.cand_valid = 1'b1;
      bus.cand_hash = {32{4'h1}};
      bus.cand_tag = 32'd11;
      #1;
      for (int c = 1; c <= 36; c++) begin
         tick();
         if (c == 1) bus.cand_valid = 1'b0;
         if (bus.chk_checkrdy) nchk++;
         if (bus.res_valid) nres++;
         if (c == 33) begin
            checks++;
            if (bus.err !== 1'b0) begin errors++; $display("FAIL err_early got=%b want=0", bus.err); end
         end
         if (c == 34) begin
            checks++;
            if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set got=%b want=1", bus.err); end
         end
         if (c == 35) begin
            bus.load_valid = 1'b1;
            bus.cand_valid = 1'b1;
            #1;
            checks++;
            if ({bus.load_ready, bus.cand_ready, bus.busy} !== 3'b001) begin
               errors++; $display("FAIL error_ready got=%b want=001", {bus.load_ready, bus.cand_ready, bus.busy});
            end
            bus.load_valid = 1'b0;
            bus.cand_valid = 1'b0;
         end
      end
      checks++;
      if (nchk !== 1 || nres !== 0) begin errors++; $display("FAIL timeout_strobes got=%0d/%0d want=1/0", nchk, nres); end
      rst = 1'b1;
      model_dead = 1'b0;
      tick(); tick();
      checks++;
      if ({bus.err, bus.busy} !== 2'b00 || bus.loaded_count !== 8'd0 || bus.hit_count !== 16'd0) begin
         errors++; $display("FAIL rst_clear got=%b/%0d/%0d want=00/0/0", {bus.err, bus.busy}, bus.loaded_count, bus.hit_count);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b want=1", bus.load_ready); end
   endtask

   initial begin
      bus.load_valid = 1'b0;
      bus.load_hash = 128'h0;
      bus.cand_valid = 1'b0;
      bus.cand_hash = 128'h0;
      bus.cand_tag = 32'h0;
      bus.chk_resultrdy = 1'b0;
      bus.chk_matchfound = 1'b0;
      test_reset();
      test_no_targets();
      test_load();
      test_candidates();
      test_zero_mask();
      test_full();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hashcheck_initiator.md
Name: hashcheck_initiator

Overview:
- Drives the request side of the hashchecker handshake (newrdy/checkrdy/hash in, resultrdy/matchfound back).
- Accepts target hashes from the host loader and loads them into the checker.
- Accepts candidate hashes from the NT-hash pipeline and queries the checker for each one.
- Emits one tagged match/no-match result per candidate, and guards against checker stalls with a timeout.

Parameters:
- MAX_HASHES, 128: checker capacity; loads beyond this count are refused.
- TAG_W, 32: width of the candidate tag (password index) carried through to the result.
- TIMEOUT, 31: maximum cycles spent in any wait state before the error state is entered.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  target hash offered
- load_hash  in  128  target hash
- load_ready  out  1  target accepted when load_valid && load_ready
- cand_valid  in  1  candidate offered
- cand_hash  in  128  candidate NT hash
- cand_tag  in  TAG_W  candidate identifier
- cand_ready  out  1  candidate accepted when cand_valid && cand_ready
- chk_newrdy  out  1  to checker newrdy; one-cycle pulse
- chk_checkrdy  out  1  to checker checkrdy; one-cycle pulse
- chk_hash  out  128  to checker hash; held stable for the whole transaction
- chk_resultrdy  in  1  from checker resultrdy
- chk_matchfound  in  1  from checker matchfound
- res_valid  out  1  one-cycle result pulse
- res_match  out  1  match flag, valid with res_valid
- res_tag  out  TAG_W  tag of the checked candidate
- loaded_count  out  8  number of targets loaded (0..MAX_HASHES)
- hit_count  out  16  number of matches; saturates at 0xFFFF
- err  out  1  sticky timeout flag
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: every output is 0, state is IDLE, the zero_loaded flag is 0, and the timer is 0. rst is applied together with the checker reset; a reset mid-transaction abandons the transaction with no res_valid.
- Ready signals (both combinational from the registered state):
  - load_ready = (state==IDLE) && loaded_count<MAX_HASHES.
  - cand_ready = (state==IDLE) && !load_valid. Loads take priority when both are offered.
- State machine:
  - IDLE:
    - load accept: chk_hash<=load_hash; set zero_loaded if load_hash==0; go to LREQ.
    - cand accept with loaded_count==0: no checker query; next cycle res_valid=1, res_match=0.
    - other cand accept: chk_hash<=cand_hash, tag latched, go to CREQ.
  - LREQ: chk_newrdy=1 for this cycle only; go to LWAIT.
  - LWAIT: on chk_resultrdy=1, loaded_count+1 and go to DRAIN.
  - CREQ: chk_checkrdy=1 for this cycle only; go to CWAIT.
  - CWAIT: on chk_resultrdy=1, capture chk_matchfound and go to REPORT.
  - REPORT: res_valid=1 for one cycle; hit_count increments if res_match; go to DRAIN.
  - DRAIN: stay until chk_resultrdy==0, then go to IDLE. No new request may be issued while resultrdy is still high; this prevents double-counting the two-cycle check acknowledge.
  - ERROR: err=1; all strobes stay 0; both readies stay 0. Exit only via rst.
- Zero-hash masking: unused checker slots hold 0. If cand_hash==0 && !zero_loaded && loaded_count<MAX_HASHES, res_match is forced to 0 regardless of chk_matchfound.
- Timeout: the timer clears on every state change and counts each cycle spent in LWAIT, CWAIT or DRAIN. When timer==TIMEOUT, go to ERROR.
- Latency against the team's hashchecker (accept = cycle 0):
  - Load: chk_newrdy in cycle 1; loaded_count updates after cycle 5; load_ready high again in cycle 7.
  - Check: chk_checkrdy in cycle 1; res_valid in cycle 6; cand_ready high again in cycle 8.
- chk_hash changes only at IDLE acceptance.

Decomposition:
- Package hashcheck_pkg holds HASH_W=128, the state enumeration (IDLE, LREQ, LWAIT, CREQ, CWAIT, REPORT, DRAIN, ERROR) and the default MAX_HASHES.
- One sub-module, hashcheck_wait_timer: a clear/enable counter with an expiry flag at TIMEOUT, instantiated once.

Test Plan:
- Load 0x11..11 then 0x22..22 -> exactly one chk_newrdy per load, loaded_count=2; chk_hash stable until resultrdy falls; load_ready returns in cycle 7.
- Candidate 0x22..22, tag 5 -> chk_checkrdy in cycle 1; res_valid in cycle 6 with res_match=1, res_tag=5; hit_count=1. Candidate 0x33..33, tag 6 -> res_match=0.
- Candidate before any load, tag 9 -> no chk_checkrdy; res_valid in cycle 1 with res_match=0.
- Candidate 0 with 2 non-zero targets loaded -> res_match=0. Load 0, then check 0 -> res_match=1.
- 128 loads -> loaded_count=128, load_ready stays 0; a 129th load_valid is held off; candidates still accepted.
- chk_resultrdy tied low after a CREQ -> err=1 at TIMEOUT cycles into CWAIT; res_valid never asserts; rst clears err and both counters.
